// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: writeback scheduler and scoreboard for the 32x32 register file.
// Round-robin arbitration shares the single write port among NREQ writeback sources,
// and a busy-bit scoreboard lets issue logic stall on RAW/WAW hazards.
// Optional feature macro: REGFILE_WB_BYPASS_EN (write-through forwarding during rf_wen).
module regfile_wb_sched #(
  parameter int NREQ = 2,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_ready,
  input  logic [4:0]           rs1_addr,
  input  logic [4:0]           rs2_addr,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic                 rs1_fwd_vld,
  output logic [XLEN-1:0]      rs1_fwd_data,
  output logic                 rs2_fwd_vld,
  output logic [XLEN-1:0]      rs2_fwd_data,
  input  logic [NREQ-1:0]      wb_valid,
  input  logic [NREQ*5-1:0]    wb_rd,
  input  logic [NREQ*XLEN-1:0] wb_data,
  output logic [NREQ-1:0]      wb_ready,
  output logic                 rf_wen,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata
);

  // The pointer is two bits wide so it covers up to four requesters.
  logic [31:0]     busy_q, busy_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            rf_wen_q, rf_wen_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            gnt_found;
  logic [1:0]      gnt_idx;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;
  logic            issue_set;

  // Round-robin search starting at rr_ptr; first valid source found gets the grant.
  always_comb begin
    int idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_rd    = '0;
    gnt_data  = '0;
    wb_ready  = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!gnt_found && wb_valid[idx]) begin
        gnt_found     = 1'b1;
        gnt_idx       = idx[1:0];
        gnt_rd        = wb_rd[5*idx +: 5];
        gnt_data      = wb_data[XLEN*idx +: XLEN];
        wb_ready[idx] = 1'b1;
      end
    end
  end

  // Next pointer and the registered write port; a grant to x0 is accepted but never written.
  always_comb begin
    int nxt;
    nxt        = int'(gnt_idx) + 1;
    if (nxt >= NREQ) nxt = 0;
    rr_ptr_d   = gnt_found ? nxt[1:0] : rr_ptr_q;
    rf_wen_d   = gnt_found && (gnt_rd != 5'd0);
    rf_waddr_d = gnt_found ? gnt_rd : rf_waddr_q;
    rf_wdata_d = gnt_found ? gnt_data : rf_wdata_q;
  end

  // Issue-side hazard check: one in-flight write per register, x0 is never tracked.
  always_comb begin
    issue_ready = (issue_rd == 5'd0) || !busy_q[issue_rd];
    issue_set   = issue_valid && issue_ready && (issue_rd != 5'd0);
  end

  // Scoreboard update: clear on the committed write, then set from issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
    if (issue_set) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Source hazard queries, optionally bypassing the value being written this cycle.
  always_comb begin
    logic hit1, hit2;
    rs1_busy     = (rs1_addr != 5'd0) && busy_q[rs1_addr];
    rs2_busy     = (rs2_addr != 5'd0) && busy_q[rs2_addr];
    rs1_fwd_vld  = 1'b0;
    rs2_fwd_vld  = 1'b0;
    rs1_fwd_data = '0;
    rs2_fwd_data = '0;
    hit1 = rf_wen_q && (rf_waddr_q == rs1_addr) && (rs1_addr != 5'd0)
           && !(issue_set && (issue_rd == rs1_addr));
    hit2 = rf_wen_q && (rf_waddr_q == rs2_addr) && (rs2_addr != 5'd0)
           && !(issue_set && (issue_rd == rs2_addr));
`ifdef REGFILE_WB_BYPASS_EN
    if (hit1) begin
      rs1_busy     = 1'b0;
      rs1_fwd_vld  = 1'b1;
      rs1_fwd_data = rf_wdata_q;
    end
    if (hit2) begin
      rs2_busy     = 1'b0;
      rs2_fwd_vld  = 1'b1;
      rs2_fwd_data = rf_wdata_q;
    end
`else
    hit1 = 1'b0;
    hit2 = 1'b0;
    rs1_busy = rs1_busy | hit1;
    rs2_busy = rs2_busy | hit2;
`endif
  end

  // State registers; reset drops any pending write and clears the scoreboard.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      rr_ptr_q   <= '0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      busy_q     <= busy_d;
      rr_ptr_q   <= rr_ptr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: table-driven bench for regfile_wb_sched (NREQ=2, XLEN=32),
// plus a hand-written reset-in-flight sequence.
module tb_regfile_wb_sched;

`ifdef REGFILE_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  localparam logic NB = !BYP;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rs1_fwd_vld, rs2_fwd_vld;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
  logic [1:0]  wb_valid;
  logic [9:0]  wb_rd;
  logic [63:0] wb_data;
  logic [1:0]  wb_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  wv;
    logic [4:0]  wrd0;
    logic [4:0]  wrd1;
    logic [31:0] wd0;
    logic [31:0] wd1;
    logic        e_ready;
    logic        e_rs1b;
    logic        e_rs2b;
    logic [1:0]  e_wbr;
    logic        e_wen;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_f1v;
    logic [31:0] e_f1d;
    logic        e_f2v;
    logic [31:0] e_f2d;
  } vec_t;

  vec_t vecs[18];

  regfile_wb_sched #(.NREQ(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_fwd_vld(rs1_fwd_vld), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_vld(rs2_fwd_vld), .rs2_fwd_data(rs2_fwd_data),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Single field comparison with a FAIL line on mismatch.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector's inputs (called just after a falling edge).
  task automatic applyStimulus(input vec_t v);
    issue_valid = v.iv;
    issue_rd    = v.ird;
    rs1_addr    = v.rs1;
    rs2_addr    = v.rs2;
    wb_valid    = v.wv;
    wb_rd       = {v.wrd1, v.wrd0};
    wb_data     = {v.wd1, v.wd0};
  endtask

  // Compare every output against the vector's expectations.
  task automatic checkOutput(input int n, input vec_t v);
    string t;
    t = $sformatf("v%0d", n);
    chk({t, " issue_ready"}, 32'(issue_ready), 32'(v.e_ready));
    chk({t, " rs1_busy"}, 32'(rs1_busy), 32'(v.e_rs1b));
    chk({t, " rs2_busy"}, 32'(rs2_busy), 32'(v.e_rs2b));
    chk({t, " wb_ready"}, 32'(wb_ready), 32'(v.e_wbr));
    chk({t, " rf_wen"}, 32'(rf_wen), 32'(v.e_wen));
    if (v.e_wen) begin
      chk({t, " rf_waddr"}, 32'(rf_waddr), 32'(v.e_waddr));
      chk({t, " rf_wdata"}, rf_wdata, v.e_wdata);
    end
    chk({t, " rs1_fwd_vld"}, 32'(rs1_fwd_vld), 32'(v.e_f1v));
    chk({t, " rs1_fwd_data"}, rs1_fwd_data, v.e_f1d);
    chk({t, " rs2_fwd_vld"}, 32'(rs2_fwd_vld), 32'(v.e_f2v));
    chk({t, " rs2_fwd_data"}, rs2_fwd_data, v.e_f2d);
  endtask

  initial begin
    vec_t v;
    // iv ird rs1 rs2 wv wrd0 wrd1 wd0 wd1 | ready rs1b rs2b wbr wen waddr wdata f1v f1d f2v f2d
    vecs[0]  = '{1, 5, 5, 0, 2'b00, 0, 0, 0, 0,                 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 5, 0, 2'b01, 5, 0, 32'hDEADBEEF, 0,      1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 5, 0, 2'b00, 0, 0, 0, 0,                 1, NB, 0, 2'b00, 1, 5, 32'hDEADBEEF,
                 BYP, BYP ? 32'hDEADBEEF : 32'h0, 0, 0};
    vecs[3]  = '{1, 7, 5, 0, 2'b00, 0, 0, 0, 0,                 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{1, 7, 0, 7, 2'b10, 0, 7, 0, 32'h77,            0, 0, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0};
    vecs[5]  = '{1, 7, 0, 7, 2'b00, 0, 0, 0, 0,                 0, 0, NB, 2'b00, 1, 7, 32'h77,
                 0, 0, BYP, BYP ? 32'h77 : 32'h0};
    vecs[6]  = '{1, 7, 0, 7, 2'b00, 0, 0, 0, 0,                 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 7, 0, 2'b11, 1, 2, 32'h100, 32'h200,     1, 1, 0, 2'b01, 0, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 7, 0, 2'b11, 1, 2, 32'h100, 32'h200,     1, 1, 0, 2'b10, 1, 1, 32'h100, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 7, 0, 2'b11, 1, 2, 32'h100, 32'h200,     1, 1, 0, 2'b01, 1, 2, 32'h200, 0, 0, 0, 0};
    vecs[10] = '{1, 0, 0, 0, 2'b01, 0, 0, 32'h1234, 0,          1, 0, 0, 2'b01, 1, 1, 32'h100, 0, 0, 0, 0};
    vecs[11] = '{1, 0, 0, 0, 2'b00, 0, 0, 0, 0,                 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 2'b11, 3, 4, 32'h33, 32'h44,       1, 0, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{0, 0, 7, 0, 2'b00, 0, 0, 0, 0,                 1, 1, 0, 2'b00, 1, 4, 32'h44, 0, 0, 0, 0};
    vecs[14] = '{1, 3, 0, 3, 2'b00, 0, 0, 0, 0,                 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};
    vecs[15] = '{0, 0, 0, 3, 2'b01, 3, 0, 32'h55, 0,            1, 0, 1, 2'b01, 0, 0, 0, 0, 0, 0, 0};
    vecs[16] = '{0, 0, 0, 3, 2'b00, 0, 0, 0, 0,                 1, 0, NB, 2'b00, 1, 3, 32'h55,
                 0, 0, BYP, BYP ? 32'h55 : 32'h0};
    vecs[17] = '{0, 0, 0, 3, 2'b00, 0, 0, 0, 0,                 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0};

    rst = 1'b1;
    v = '{default: '0};
    applyStimulus(v);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset rf_wen", 32'(rf_wen), 32'h0);
    chk("reset rf_waddr", 32'(rf_waddr), 32'h0);
    chk("reset rf_wdata", rf_wdata, 32'h0);
    chk("reset wb_ready", 32'(wb_ready), 32'h0);
    chk("reset issue_ready", 32'(issue_ready), 32'h1);

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(i, vecs[i]);
    end

    // Reset with busy[9]=1 and a grant to source 1 on the resetting edge.
    @(negedge clk);
    v = '{default: '0};
    v.iv = 1'b1; v.ird = 5'd9; v.rs1 = 5'd9;
    applyStimulus(v);
    #1;
    chk("rst_seq issue9 ready", 32'(issue_ready), 32'h1);
    @(negedge clk);
    v = '{default: '0};
    v.rs1 = 5'd9; v.wv = 2'b10; v.wrd1 = 5'd9; v.wd1 = 32'h99;
    applyStimulus(v);
    #1;
    chk("rst_seq rs1_busy before", 32'(rs1_busy), 32'h1);
    chk("rst_seq grant before", 32'(wb_ready), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    v = '{default: '0};
    v.ird = 5'd9; v.rs1 = 5'd9; v.rs2 = 5'd7;
    v.wv = 2'b11; v.wrd0 = 5'd10; v.wrd1 = 5'd11; v.wd0 = 32'hA0; v.wd1 = 32'hB0;
    applyStimulus(v);
    #1;
    chk("rst_seq rf_wen after", 32'(rf_wen), 32'h0);
    chk("rst_seq rs1_busy after", 32'(rs1_busy), 32'h0);
    chk("rst_seq rs2_busy after", 32'(rs2_busy), 32'h0);
    chk("rst_seq issue_ready after", 32'(issue_ready), 32'h1);
    chk("rst_seq first grant", 32'(wb_ready), 32'h1);
    @(negedge clk);
    v = '{default: '0};
    applyStimulus(v);
    #1;
    chk("rst_seq rf_wen commit", 32'(rf_wen), 32'h1);
    chk("rst_seq rf_waddr commit", 32'(rf_waddr), 32'd10);
    chk("rst_seq rf_wdata commit", rf_wdata, 32'hA0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
